pc_select_unit: RTL and testbench

PC_SELECT_UNIT -- requirements
Module: pc_select_unit

---
 rtl/y86_pkg.sv | 28 ++
 rtl/pc_select_unit_if.sv | 30 +++
 rtl/pc_select_unit_predict.sv | 33 +++
 rtl/pc_select_unit.sv | 65 ++++++
 tb/tb_pc_select_unit.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes, write-back status encodings and the
// fetch-PC selector state encoding.
package y86_pkg;

   localparam logic [3:0] IHALT = 4'h0;
   localparam logic [3:0] INOP  = 4'h1;
   localparam logic [3:0] IJXX  = 4'h7;
   localparam logic [3:0] ICALL = 4'h8;
   localparam logic [3:0] IRET  = 4'h9;

   typedef enum logic [1:0] {
      STAT_AOK = 2'd0,
      STAT_HLT = 2'd1,
      STAT_ADR = 2'd2,
      STAT_INS = 2'd3
   } stat_t;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_RET_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } pcu_state_t;

   function automatic logic stat_ok(input logic [1:0] s);
      return s == STAT_AOK;
   endfunction

endpackage

// File: rtl/pc_select_unit_if.sv
// Pipeline-side bundle of the fetch PC selector: fetch/memory/write-back
// inputs driven by the master, registered PC and FSM state returned by the slave.
interface pc_select_unit_if #(
   parameter int ADDR_W = 64
);
   logic [3:0]        f_icode;
   logic [ADDR_W-1:0] f_valc;
   logic [ADDR_W-1:0] f_valp;
   logic              stall;
   logic              m_mispredict;
   logic [ADDR_W-1:0] m_valp;
   logic              w_ret;
   logic [ADDR_W-1:0] w_valm;
   logic [1:0]        status;
   logic [ADDR_W-1:0] pc;
   logic              pc_valid;
   logic [1:0]        state;

   modport master (
      output f_icode, f_valc, f_valp, stall, m_mispredict, m_valp,
             w_ret, w_valm, status,
      input  pc, pc_valid, state
   );

   modport slave (
      input  f_icode, f_valc, f_valp, stall, m_mispredict, m_valp,
             w_ret, w_valm, status,
      output pc, pc_valid, state
   );
endinterface

// File: rtl/pc_select_unit_predict.sv
// Combinational next-PC prediction from the fetched instruction.
// Build option PCU_BTFN_PREDICT_EN: jXX taken only when the target is backward.
module pc_predict
   import y86_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic [3:0]        icode,
   input  logic [ADDR_W-1:0] valc,
   input  logic [ADDR_W-1:0] valp,
   output logic [ADDR_W-1:0] pred_pc,
   output logic              pred_ret
);

   always_comb begin
      pred_pc  = valp;
      pred_ret = 1'b0;
      case (icode)
         IJXX: begin
`ifdef PCU_BTFN_PREDICT_EN
            pred_pc = (valc < valp) ? valc : valp;
`else
            pred_pc = valc;
`endif
         end
         ICALL:   pred_pc  = valc;
         // Return address is unknown until write-back; the FSM holds pc.
         IRET:    pred_ret = 1'b1;
         default: pred_pc  = valp;
      endcase
   end

endmodule

// File: rtl/pc_select_unit.sv
// Fetch PC register and RUN/RET_WAIT/HALT control; state advances on negedge clk.
// Build option PCU_BTFN_PREDICT_EN selects backward-taken jXX prediction in pc_predict.
module pc_select_unit
   import y86_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic               clk,
   input logic               rst_n,
   pc_select_unit_if.slave   bus
);

   logic [ADDR_W-1:0] pred_pc;
   logic              pred_ret;
   logic [ADDR_W-1:0] pc_q;
   logic              valid_q;
   pcu_state_t        state_q;

   pc_predict #(.ADDR_W(ADDR_W)) u_pred (
      .icode    (bus.f_icode),
      .valc     (bus.f_valc),
      .valp     (bus.f_valp),
      .pred_pc  (pred_pc),
      .pred_ret (pred_ret)
   );

   // m_valp is taken verbatim, so it serves both not-taken and taken corrections.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         state_q <= ST_RUN;
         valid_q <= 1'b1;
      end else if (state_q == ST_HALT) begin
         state_q <= ST_HALT;
         valid_q <= 1'b0;
      end else if (!stat_ok(bus.status)) begin
         state_q <= ST_HALT;
         valid_q <= 1'b0;
      end else if (bus.m_mispredict) begin
         pc_q    <= bus.m_valp;
         state_q <= ST_RUN;
         valid_q <= 1'b1;
      end else if (state_q == ST_RET_WAIT) begin
         if (bus.w_ret) begin
            pc_q    <= bus.w_valm;
            state_q <= ST_RUN;
            valid_q <= 1'b1;
         end
      end else if (!bus.stall) begin
         if (pred_ret) begin
            state_q <= ST_RET_WAIT;
            valid_q <= 1'b0;
         end else begin
            pc_q    <= pred_pc;
            valid_q <= 1'b1;
         end
      end
   end

   assign bus.pc       = pc_q;
   assign bus.pc_valid = valid_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_pc_select_unit.sv
// Directed scoreboard bench for pc_select_unit: expected results are queued
// with each stimulus and checked by a separate monitor on the rising edge.
module tb_pc_select_unit;

   localparam int          AW   = 64;
   localparam logic [63:0] RPC  = 64'h100;
   localparam logic [63:0] ONES = '1;

   typedef struct {
      string       name;
      logic [63:0] pc;
      logic        vld;
      logic [1:0]  st;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;
   exp_t sb[$];

   pc_select_unit_if #(.ADDR_W(AW)) bus ();

   pc_select_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input string fld, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %h expected %h", name, fld, act, exp);
      end
   endtask

   task automatic chk_now(input string name, input logic [63:0] p, input logic v,
                          input logic [1:0] s);
      cmp(name, "pc", bus.pc, p);
      cmp(name, "pc_valid", {63'd0, bus.pc_valid}, {63'd0, v});
      cmp(name, "state", {62'd0, bus.state}, {62'd0, s});
   endtask

   // Monitor: DUT updates on negedge, so the rising edge is a quiet sample point.
   always @(posedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk_now(e.name, e.pc, e.vld, e.st);
      end
   end

   task automatic drive(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                        input logic st, input logic mis, input logic [63:0] mv,
                        input logic wr, input logic [63:0] wm, input logic [1:0] stat);
      bus.f_icode      = ic;
      bus.f_valc       = vc;
      bus.f_valp       = vp;
      bus.stall        = st;
      bus.m_mispredict = mis;
      bus.m_valp       = mv;
      bus.w_ret        = wr;
      bus.w_valm       = wm;
      bus.status       = stat;
   endtask

   task automatic step(input string name, input logic [3:0] ic, input logic [63:0] vc,
                       input logic [63:0] vp, input logic st, input logic mis,
                       input logic [63:0] mv, input logic wr, input logic [63:0] wm,
                       input logic [1:0] stat, input logic [63:0] ep, input logic ev,
                       input logic [1:0] es);
      exp_t e;
      @(posedge clk);
      #1;
      drive(ic, vc, vp, st, mis, mv, wr, wm, stat);
      e.name = name; e.pc = ep; e.vld = ev; e.st = es;
      sb.push_back(e);
   endtask

   task automatic do_reset(input string name);
      @(posedge clk);
      #1;
      drive(4'h1, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 2'd0);
      rst_n = 1'b0;
      #1;
      chk_now(name, RPC, 1'b1, 2'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [63:0] e_fwd;
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b1;
      drive(4'h1, 64'h0, 64'h100, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 2'd0);
      #1 rst_n = 1'b0;
      #1 chk_now("reset_async", RPC, 1'b1, 2'd0);
      rst_n = 1'b1;

`ifdef PCU_BTFN_PREDICT_EN
      e_fwd = 64'h20;
`else
      e_fwd = 64'h40;
`endif
      //    name          ic    valc       valp       stl  mis  m_valp     wr   w_valm     stat  exp_pc     v     st
      step("nop_fall",    4'h1, 64'h0,     64'h10A,   1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h10A,   1'b1, 2'd0);
      step("jxx_fwd",     4'h7, 64'h40,    64'h20,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, e_fwd,     1'b1, 2'd0);
      step("mispredict",  4'h7, 64'h40,    64'h20,    1'b0,1'b1,64'h20,    1'b0,64'h0,     2'd0, 64'h20,    1'b1, 2'd0);
      step("call",        4'h8, 64'h30,    64'h29,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h30,    1'b1, 2'd0);
      step("ret_enter",   4'h9, 64'h0,     64'h31,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h30,    1'b0, 2'd1);
      step("ret_wait1",   4'h9, 64'h0,     64'h31,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h30,    1'b0, 2'd1);
      step("ret_wait2",   4'h1, 64'h0,     64'h31,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h30,    1'b0, 2'd1);
      step("ret_resolve", 4'h9, 64'h0,     64'h31,    1'b0,1'b0,64'h0,     1'b1,64'h88,    2'd0, 64'h88,    1'b1, 2'd0);
      step("wret_in_run", 4'h1, 64'h0,     64'h8A,    1'b0,1'b0,64'h0,     1'b1,64'h77,    2'd0, 64'h8A,    1'b1, 2'd0);
      step("stall_hold",  4'h0, 64'h0,     64'h10,    1'b1,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h8A,    1'b1, 2'd0);
      step("stall_mis",   4'h0, 64'h0,     64'h10,    1'b1,1'b1,64'h50,    1'b0,64'h0,     2'd0, 64'h50,    1'b1, 2'd0);
      step("ret_enter2",  4'h9, 64'h0,     64'h51,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h50,    1'b0, 2'd1);
      step("retwait_mis", 4'h9, 64'h0,     64'h51,    1'b0,1'b1,64'h60,    1'b0,64'h0,     2'd0, 64'h60,    1'b1, 2'd0);
      step("jxx_back",    4'h7, 64'h08,    64'h20,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h08,    1'b1, 2'd0);
      step("valp_ones",   4'h2, 64'h0,     ONES,      1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, ONES,      1'b1, 2'd0);
      step("ret_enter3",  4'h9, 64'h0,     64'h0,     1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, ONES,      1'b0, 2'd1);
      step("halt_vs_ret", 4'h1, 64'h0,     64'h0,     1'b0,1'b0,64'h0,     1'b1,64'h99,    2'd2, ONES,      1'b0, 2'd2);
      step("halt_mis",    4'h7, 64'h40,    64'h20,    1'b0,1'b1,64'h55,    1'b0,64'h0,     2'd0, ONES,      1'b0, 2'd2);
      step("halt_wret",   4'h1, 64'h0,     64'h20,    1'b0,1'b0,64'h0,     1'b1,64'h99,    2'd0, ONES,      1'b0, 2'd2);
      do_reset("reset_from_halt");
      step("halt_vs_mis", 4'h1, 64'h0,     64'h20,    1'b0,1'b1,64'h44,    1'b0,64'h0,     2'd3, RPC,       1'b0, 2'd2);
      do_reset("reset_again");
`ifdef PCU_BTFN_PREDICT_EN
      step("jxx_fwd2",    4'h7, 64'h80,    64'h20,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h20,    1'b1, 2'd0);
`else
      step("jxx_fwd2",    4'h7, 64'h80,    64'h20,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h80,    1'b1, 2'd0);
`endif
      step("call_after",  4'h8, 64'h200,   64'h8A,    1'b0,1'b0,64'h0,     1'b0,64'h0,     2'd0, 64'h200,   1'b1, 2'd0);

      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
